brew_sequencer: RTL and testbench



---
 rtl/brew_sequencer.sv | 173 +++++++++++++++++
 tb/tb_brew_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brew_sequencer.sv
// brew_sequencer: timed brewing stage (pressurise -> heat -> deliver -> done).
// It takes the "drink accepted" pulse plus the drink code, runs each phase for
// a fixed number of timebase ticks, and drives the status indicators and the
// 10-LED delivery progress bar. Water loss during an active phase aborts to FAULT.
module brew_sequencer #(
  parameter int PRESS_TICKS = 3,
  parameter int HEAT_TICKS  = 5,
  parameter int DONE_TICKS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic [1:0] drink_sel,
  input  logic       water_ok,
  output logic       busy,
  output logic       pressurize,
  output logic       heating,
  output logic       delivering,
  output logic [9:0] led_bar,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_HEAT    = 3'd2,
    S_DELIVER = 3'd3,
    S_DONE    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [3:0] PRESS_LEN = 4'(PRESS_TICKS);
  localparam logic [3:0] HEAT_LEN  = 4'(HEAT_TICKS);
  localparam logic [3:0] DONE_LEN  = 4'(DONE_TICKS);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  drink_q, drink_d;
  logic [9:0]  led_q, led_d;
  logic        busy_q, press_q, heat_q, dlv_q, done_q, fault_q;
  logic [3:0]  deliver_len;

  // Delivery length scales with the latched drink: 4/6/8/10 ticks.
  assign deliver_len = 4'd4 + {1'b0, drink_q, 1'b0};

  // Next-state, phase counter, drink latch and progress bar update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drink_d = drink_q;
    led_d   = led_q;
    case (state_q)
      S_IDLE: begin
        // A tick coinciding with start is deliberately not counted.
        if (start) begin
          if (water_ok) begin
            drink_d = drink_sel;
            state_d = S_PRESS;
            cnt_d   = PRESS_LEN;
          end else begin
            state_d = S_FAULT;
            cnt_d   = 4'd0;
          end
        end
      end
      S_PRESS: begin
        if (!water_ok) begin
          state_d = S_FAULT;
          cnt_d   = 4'd0;
        end else if (tick) begin
          if (cnt_q == 4'd1) begin
            state_d = S_HEAT;
            cnt_d   = HEAT_LEN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_HEAT: begin
        if (!water_ok) begin
          state_d = S_FAULT;
          cnt_d   = 4'd0;
        end else if (tick) begin
          if (cnt_q == 4'd1) begin
            state_d = S_DELIVER;
            cnt_d   = deliver_len;
            led_d   = 10'h000;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_DELIVER: begin
        if (!water_ok) begin
          state_d = S_FAULT;
          cnt_d   = 4'd0;
          led_d   = 10'h000;
        end else if (tick) begin
          led_d = {led_q[8:0], 1'b1};
          if (cnt_q == 4'd1) begin
            // The bar is shown full for the whole DONE state, whatever the drink.
            state_d = S_DONE;
            cnt_d   = DONE_LEN;
            led_d   = 10'h3FF;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_DONE: begin
        if (tick) begin
          if (cnt_q == 4'd1) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            led_d   = 10'h000;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_FAULT: begin
        led_d = 10'h000;
        if (tick && water_ok) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        led_d   = 10'h000;
      end
    endcase
  end

  // State register plus registered output decode (no input-to-output path).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      drink_q <= 2'd0;
      led_q   <= 10'h000;
      busy_q  <= 1'b0;
      press_q <= 1'b0;
      heat_q  <= 1'b0;
      dlv_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drink_q <= drink_d;
      led_q   <= led_d;
      busy_q  <= (state_d != S_IDLE);
      press_q <= (state_d == S_PRESS);
      heat_q  <= (state_d == S_HEAT);
      dlv_q   <= (state_d == S_DELIVER);
      done_q  <= (state_d == S_DONE) && (state_q != S_DONE);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign busy       = busy_q;
  assign pressurize = press_q;
  assign heating    = heat_q;
  assign delivering = dlv_q;
  assign led_bar    = led_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed testbench for brew_sequencer: each scenario task drives stimulus
// and checks outputs against hand-computed values one cycle after each edge.
module tb_brew_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic [1:0] drink_sel;
  logic       water_ok;
  logic       busy, pressurize, heating, delivering, done, fault;
  logic [9:0] led_bar;

  int errors = 0;
  int checks = 0;

  brew_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start      (start),
    .drink_sel  (drink_sel),
    .water_ok   (water_ok),
    .busy       (busy),
    .pressurize (pressurize),
    .heating    (heating),
    .delivering (delivering),
    .led_bar    (led_bar),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // One clock: present tick/start for the next edge, then sample 1 time unit after it.
  task automatic cyc(input logic t, input logic s);
    tick  = t;
    start = s;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
  endtask

  // One timebase period: three idle clocks then a tick clock.
  task automatic do_tick();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; drink_sel = 2'd0; water_ok = 1'b1;
    #2;
    checks++;
    if ({busy, pressurize, heating, delivering, led_bar, done, fault} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0000",
               {busy, pressurize, heating, delivering, led_bar, done, fault});
    end
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_tick: busy=%b required 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_espresso();
    logic [9:0] exp_led;
    water_ok = 1'b1; drink_sel = 2'd0;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pressurize !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL esp_press tick %0d: pressurize=%b busy=%b required 1 1", i, pressurize, busy);
      end
      do_tick();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (heating !== 1'b1 || pressurize !== 1'b0) begin
        errors++;
        $display("FAIL esp_heat tick %0d: heating=%b pressurize=%b required 1 0", i, heating, pressurize);
      end
      do_tick();
    end
    checks++;
    if (delivering !== 1'b1 || led_bar !== 10'h000) begin
      errors++;
      $display("FAIL esp_dlv_entry: delivering=%b led_bar=%h required 1 000", delivering, led_bar);
    end
    exp_led = 10'h000;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      exp_led = {exp_led[8:0], 1'b1};
      checks++;
      if (led_bar !== exp_led || delivering !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL esp_led step %0d: led_bar=%h dlv=%b done=%b required %h 1 0",
                 i, led_bar, delivering, done, exp_led);
      end
    end
    do_tick();
    checks++;
    if (done !== 1'b1 || led_bar !== 10'h3FF || delivering !== 1'b0) begin
      errors++;
      $display("FAIL esp_done_entry: done=%b led_bar=%h dlv=%b required 1 3ff 0", done, led_bar, delivering);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (done !== 1'b0 || led_bar !== 10'h3FF || busy !== 1'b1) begin
      errors++;
      $display("FAIL esp_done_hold: done=%b led_bar=%h busy=%b required 0 3ff 1", done, led_bar, busy);
    end
    do_tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL esp_done_tick1: busy=%b required 1", busy);
    end
    do_tick();
    checks++;
    if (busy !== 1'b0 || led_bar !== 10'h000) begin
      errors++;
      $display("FAIL esp_idle_return: busy=%b led_bar=%h required 0 000", busy, led_bar);
    end
    $display("test_espresso done");
  endtask

  task automatic test_double();
    int         nticks;
    int         ndlv;
    int         ndone;
    logic [9:0] prev_led;
    water_ok = 1'b1; drink_sel = 2'd3;
    // tick on the start edge must not be counted
    cyc(1'b1, 1'b1);
    nticks = 0; ndlv = 0; ndone = 0; prev_led = 10'h000;
    while (busy === 1'b1 && nticks < 40) begin
      if (delivering === 1'b1) ndlv++;
      prev_led = led_bar;
      do_tick();
      nticks++;
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (led_bar !== 10'h3FF || prev_led !== 10'h1FF) begin
          errors++;
          $display("FAIL dbl_done_led: led_bar=%h prev=%h required 3ff 1ff", led_bar, prev_led);
        end
      end
    end
    checks++;
    if (nticks !== 20) begin
      errors++;
      $display("FAIL dbl_busy_ticks: got %0d required 20", nticks);
    end
    checks++;
    if (ndlv !== 10) begin
      errors++;
      $display("FAIL dbl_deliver_ticks: got %0d required 10", ndlv);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL dbl_done_pulses: got %0d required 1", ndone);
    end
    $display("test_double done ticks=%0d", nticks);
  endtask

  task automatic test_water_loss();
    water_ok = 1'b1; drink_sel = 2'd0;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 3 + 4; i++) do_tick();
    checks++;
    if (heating !== 1'b1) begin
      errors++;
      $display("FAIL wl_in_heat: heating=%b required 1", heating);
    end
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    water_ok = 1'b0;
    cyc(1'b1, 1'b0);
    checks++;
    if (fault !== 1'b1 || delivering !== 1'b0 || led_bar !== 10'h000 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL wl_fault: fault=%b dlv=%b led=%h busy=%b done=%b required 1 0 000 1 0",
               fault, delivering, led_bar, busy, done);
    end
    do_tick();
    checks++;
    if (fault !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL wl_fault_hold: fault=%b done=%b required 1 0", fault, done);
    end
    water_ok = 1'b1;
    cyc(1'b0, 1'b0);
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL wl_wait_tick: fault=%b required 1", fault);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wl_recover: fault=%b busy=%b done=%b required 0 0 0", fault, busy, done);
    end
    $display("test_water_loss done");
  endtask

  task automatic test_start_no_water();
    water_ok = 1'b0; drink_sel = 2'd1;
    cyc(1'b0, 1'b1);
    checks++;
    if (fault !== 1'b1 || busy !== 1'b1 || pressurize !== 1'b0) begin
      errors++;
      $display("FAIL nw_fault: fault=%b busy=%b press=%b required 1 1 0", fault, busy, pressurize);
    end
    water_ok = 1'b1; drink_sel = 2'd3;
    cyc(1'b0, 1'b1);
    checks++;
    if (fault !== 1'b1 || pressurize !== 1'b0) begin
      errors++;
      $display("FAIL nw_second_start: fault=%b press=%b required 1 0", fault, pressurize);
    end
    // start on the recovery edge is still seen in FAULT and ignored
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL nw_recover: busy=%b fault=%b required 0 0", busy, fault);
    end
    $display("test_start_no_water done");
  endtask

  task automatic test_start_while_busy();
    int ndlv;
    int guard;
    water_ok = 1'b1; drink_sel = 2'd0;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 3 + 2; i++) do_tick();
    drink_sel = 2'd2;
    cyc(1'b0, 1'b1);
    checks++;
    if (heating !== 1'b1 || pressurize !== 1'b0) begin
      errors++;
      $display("FAIL bs_heat_kept: heating=%b press=%b required 1 0", heating, pressurize);
    end
    for (int i = 0; i < 3; i++) do_tick();
    ndlv = 0; guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      if (delivering === 1'b1) ndlv++;
      do_tick();
      guard++;
    end
    checks++;
    if (ndlv !== 4) begin
      errors++;
      $display("FAIL bs_deliver_ticks: got %0d required 4", ndlv);
    end
    do_tick(); do_tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bs_idle: busy=%b required 0", busy);
    end
    $display("test_start_while_busy done");
  endtask

  task automatic test_async_reset();
    int ndone;
    water_ok = 1'b1; drink_sel = 2'd1;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 3 + 5 + 2; i++) do_tick();
    checks++;
    if (delivering !== 1'b1 || led_bar !== 10'h003) begin
      errors++;
      $display("FAIL ar_mid_deliver: dlv=%b led=%h required 1 003", delivering, led_bar);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, pressurize, heating, delivering, led_bar, done, fault} !== 16'h0) begin
      errors++;
      $display("FAIL ar_immediate: got %h required 0000",
               {busy, pressurize, heating, delivering, led_bar, done, fault});
    end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_after_release: done_pulses=%0d busy=%b required 0 0", ndone, busy);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_espresso();
    test_double();
    test_water_loss();
    test_start_no_water();
    test_start_while_busy();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
